// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and sequences single-outstanding
// instruction fetches (req/ack to imem, valid/ready to decode). Applies
// branch redirects on decode accept and trap/exception flushes at any time.
// Optional build macro: MISALIGN_CHECK_EN -- reject jumps to non-word-aligned
// targets (fall through to instr_pc+PC_STEP and pulse jmp_misaligned).
`timescale 1ns/1ps

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        jmp_enable,
  input  logic [31:0] jmp_addr,
  input  logic        flush_req,
  input  logic [31:0] flush_addr,
  output logic        jmp_misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH,    // request outstanding (or about to launch right after reset)
    S_HOLD,     // instruction presented to decode, waiting for accept
    S_DISCARD   // request outstanding whose data must be dropped
  } state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;            // address of the next fetch to issue
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;        // address on the bus, frozen until ack
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] seq_pc, jmp_tgt, flush_tgt, next_fetch;
`ifdef MISALIGN_CHECK_EN
  logic        jmp_bad;
  logic        misal_q, misal_d;
`endif

  // Resolve redirect targets (misaligned jumps fall through when checked)
  always_comb begin
    seq_pc = instr_pc_q + PC_STEP;
`ifdef MISALIGN_CHECK_EN
    jmp_bad   = (jmp_addr[1:0] != 2'b00);
    jmp_tgt   = jmp_bad ? seq_pc : jmp_addr;
    flush_tgt = word_align(flush_addr);
`else
    jmp_tgt   = jmp_addr;
    flush_tgt = flush_addr;
`endif
  end

  // Next-state logic; flush outranks accept and jump in every state
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    next_fetch = pc_q;
`ifdef MISALIGN_CHECK_EN
    misal_d    = 1'b0;
`endif
    unique case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          // First cycle out of reset: launch the pending fetch.
          next_fetch = flush_req ? flush_tgt : pc_q;
          pc_d       = next_fetch;
          req_d      = 1'b1;
          addr_d     = word_align(next_fetch);
        end else if (imem_ack) begin
          if (flush_req) begin
            // Data arriving this cycle is stale; refetch at the flush target.
            pc_d   = flush_tgt;
            addr_d = word_align(flush_tgt);
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            req_d      = 1'b0;
            state_d    = S_HOLD;
          end
        end else if (flush_req) begin
          // Bus must stay frozen until ack, so remember the target and drain.
          pc_d    = flush_tgt;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        next_fetch = flush_req ? flush_tgt : pc_q;
        pc_d       = next_fetch;
        if (imem_ack) begin
          addr_d  = word_align(next_fetch);
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (flush_req) begin
          pc_d    = flush_tgt;
          addr_d  = word_align(flush_tgt);
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (instr_ready) begin
          next_fetch = jmp_enable ? jmp_tgt : seq_pc;
          pc_d       = next_fetch;
          addr_d     = word_align(next_fetch);
          req_d      = 1'b1;
          state_d    = S_FETCH;
`ifdef MISALIGN_CHECK_EN
          misal_d    = jmp_enable & jmp_bad;
`endif
        end
      end
      default: begin
        state_d = S_FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  // One-cycle pulse after a rejected misaligned jump
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misal_q <= 1'b0;
    else        misal_q <= misal_d;
  end
  assign jmp_misaligned = misal_q;
`else
  assign jmp_misaligned = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule
